// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants and helpers for the hex display scanner
package hex_display_pkg;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns {g,f,e,d,c,b,a} for nibbles 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bits needed to index n items; never less than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational nibble to active-low seven-segment decode
module seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for the selected nibble
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - multiplexed hex display scanner, optional blanking via HEX_SCAN_LZB_EN
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic                  load,
    input  logic                  lzb,
    output logic                  pending,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int IW = idx_width(N_DIGITS);
    localparam int SW = idx_width(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] DIG_LAST  = IW'(N_DIGITS - 1);

    logic [SW-1:0]         slot_cnt;
    logic [IW-1:0]         digit_idx;
    logic                  slot_wrap;
    logic                  frame_end;
    logic                  slot_active;

    logic [4*N_DIGITS-1:0] pend_value;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [4*N_DIGITS-1:0] shadow_value;
    logic [N_DIGITS-1:0]   shadow_dp;

    logic [3:0]            sel_nibble;
    logic                  sel_dp;
    logic [N_DIGITS-1:0]   an_sel;
    logic [6:0]            dec_seg;
    logic                  lzb_blank;

    assign slot_wrap   = (slot_cnt == SLOT_LAST);
    assign frame_end   = slot_wrap && (digit_idx == DIG_LAST);
    assign slot_active = (slot_cnt != '0);

    // Slot cycle counter and digit index; digit advances when the slot wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_wrap) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + IW'(1);
        end else begin
            slot_cnt  <= slot_cnt + SW'(1);
        end
    end

    // Double-buffered value: loads park in the pending register and reach the
    // shadow only at a frame boundary so a frame never mixes two values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_value   <= '0;
            pend_dp      <= '0;
            pending      <= 1'b0;
            shadow_value <= '0;
            shadow_dp    <= '0;
        end else if (frame_end) begin
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp;
            end else if (pending) begin
                shadow_value <= pend_value;
                shadow_dp    <= pend_dp;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
            pending    <= 1'b1;
        end
    end

    // Select the nibble, decimal point and anode pattern of the current digit
    always_comb begin
        sel_nibble = 4'd0;
        sel_dp     = 1'b0;
        an_sel     = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx == IW'(i)) begin
                sel_nibble = shadow_value[4*i +: 4];
                sel_dp     = shadow_dp[i];
                an_sel[i]  = 1'b0;
            end
        end
    end

`ifdef HEX_SCAN_LZB_EN
    logic [IW-1:0] msnz_idx;

    // Locate the most significant nonzero digit; digit 0 is always shown
    always_comb begin
        msnz_idx = '0;
        for (int i = 1; i < N_DIGITS; i++) begin
            if (shadow_value[4*i +: 4] != 4'd0) begin
                msnz_idx = IW'(i);
            end
        end
        lzb_blank = lzb && (digit_idx > msnz_idx);
    end
`else
    logic unused_lzb;

    // Blanking not built: every digit is displayed
    always_comb begin
        unused_lzb = lzb;
        lzb_blank  = 1'b0;
    end
`endif

    seg_decode u_seg_decode (
        .nibble (sel_nibble),
        .seg    (dec_seg)
    );

    // Registered drive; slot cycle 0 stays dark so the previous digit's
    // segments never ghost onto the newly enabled anode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg    <= SEG_BLANK;
            seg_dp <= 1'b1;
            an     <= '1;
        end else if (!slot_active) begin
            seg    <= SEG_BLANK;
            seg_dp <= 1'b1;
            an     <= '1;
        end else begin
            seg    <= lzb_blank ? SEG_BLANK : dec_seg;
            seg_dp <= !sel_dp;
            an     <= an_sel;
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// tb/tb_hex_display_scan.sv - self-checking bench for hex_display_scan
module tb_hex_display_scan;

    localparam int ND   = 4;
    localparam int SDIV = 4;
    localparam int FRAME = ND * SDIV;
`ifdef HEX_SCAN_LZB_EN
    localparam bit LZB_BUILD = 1'b1;
`else
    localparam bit LZB_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        lzb;
    logic        pending;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;

    int passed = 0;
    int total  = 0;

    hex_display_scan #(.N_DIGITS(ND), .SCAN_DIV(SDIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .value   (value),
        .dp      (dp),
        .load    (load),
        .lzb     (lzb),
        .pending (pending),
        .seg     (seg),
        .seg_dp  (seg_dp),
        .an      (an)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: n is the number of clock edges since reset release,
    // which fixes slot and digit by plain arithmetic
    int          n = 0;
    logic        m_pend = 1'b0;
    logic [15:0] m_pv = '0;
    logic [3:0]  m_pdp = '0;
    logic [15:0] m_shadow = '0;
    logic [3:0]  m_sdp = '0;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [3:0]  exp_an = 4'hF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    always @(posedge clk or posedge reset) begin
        int          slot, dig, top;
        logic [15:0] sh;
        if (reset) begin
            n = 0; m_pend = 0; m_pv = 0; m_pdp = 0; m_shadow = 0; m_sdp = 0;
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
        end else begin
            slot = n % SDIV;
            dig  = (n / SDIV) % ND;
            top = 0;
            for (int i = 1; i < ND; i++) if (((m_shadow >> (4*i)) & 16'hF) != 0) top = i;
            if (slot == 0) begin
                exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
            end else begin
                sh = m_shadow >> (4*dig);
                exp_an  = ~(4'b0001 << dig);
                exp_seg = (LZB_BUILD && lzb && dig > top) ? 7'h7F : tbl[sh[3:0]];
                exp_dp  = !m_sdp[dig];
            end
            if (slot == SDIV-1 && dig == ND-1) begin
                if (load) begin m_shadow = value; m_sdp = dp; end
                else if (m_pend) begin m_shadow = m_pv; m_sdp = m_pdp; end
                m_pend = 0;
            end else if (load) begin
                m_pv = value; m_pdp = dp; m_pend = 1;
            end
            n++;
        end
    end

    always @(negedge clk) begin
        chk("model_seg", seg, exp_seg);
        chk("model_seg_dp", seg_dp, exp_dp);
        chk("model_an", an, exp_an);
        chk("model_pending", pending, m_pend);
    end

    logic [3:0] cap_an  [17];
    logic [6:0] cap_seg [17];
    logic       cap_dp  [17];

    task automatic wait_state(input int target);
        int k;
        for (k = 0; k < 4*FRAME; k++) begin
            @(posedge clk); #1;
            if (n % FRAME == target) break;
        end
        if (k == 4*FRAME) chk("wait_state_timeout", 0, 1);
    endtask

    // cap[j] holds the outputs produced from counter state (frame start - 1 + j)
    task automatic capture_frame();
        wait_state(0);
        cap_an[0] = an; cap_seg[0] = seg; cap_dp[0] = seg_dp;
        for (int j = 1; j < 17; j++) begin
            @(posedge clk); #1;
            cap_an[j] = an; cap_seg[j] = seg; cap_dp[j] = seg_dp;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(posedge clk); #2;
        value = v; dp = d; load = 1'b1;
        @(posedge clk); #2;
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; value = '0; dp = '0; load = 1'b0; lzb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg", seg, 7'h7F);
        chk("reset_an", an, 4'hF);
        chk("reset_pending", pending, 1'b0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rel_first_an", an, 4'hF);
        @(posedge clk); #1;
        chk("rel_second_an", an, 4'hE);

        // Scan of 12AF
        do_load(16'h12AF, 4'b0000);
        chk("scan_pending_set", pending, 1'b1);
        capture_frame();
        chk("scan_pending_clr", pending, 1'b0);
        chk("scan_an0", cap_an[2], 4'hE);   chk("scan_seg0", cap_seg[2], 7'h0E);
        chk("scan_an1", cap_an[6], 4'hD);   chk("scan_seg1", cap_seg[6], 7'h08);
        chk("scan_an2", cap_an[10], 4'hB);  chk("scan_seg2", cap_seg[10], 7'h24);
        chk("scan_an3", cap_an[14], 4'h7);  chk("scan_seg3", cap_seg[14], 7'h79);
        chk("scan_dp0", cap_dp[2], 1'b1);
        chk("scan_blank_slot0", cap_an[1], 4'hF);

        // Tearing: mid-frame load waits for the boundary
        wait_state(5);
        do_load(16'h0001, 4'b0000);
        chk("tear_pending", pending, 1'b1);
        wait_state(14);
        chk("tear_old_an", an, 4'h7);
        chk("tear_old_seg", seg, 7'h79);
        capture_frame();
        chk("tear_pending_clr", pending, 1'b0);
        chk("tear_new_seg0", cap_seg[2], 7'h79);
        chk("tear_new_seg3", cap_seg[14], 7'h40);

        // Coincident load on the boundary cycle wins over the pending one
        wait_state(3);
        do_load(16'h1111, 4'b0000);
        wait_state(7);
        do_load(16'h2222, 4'b0000);
        wait_state(FRAME-1);
        #1 value = 16'h3333; load = 1'b1;
        @(posedge clk); #2;
        load = 1'b0;
        chk("coin_pending", pending, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("coin_an", an, 4'hE);
        chk("coin_seg", seg, 7'h30);

        // Leading-zero blanking
        lzb = 1'b1;
        do_load(16'h0050, 4'b0000);
        capture_frame();
        capture_frame();
        chk("lzb_d3", cap_seg[14], LZB_BUILD ? 7'h7F : 7'h40);
        chk("lzb_d2", cap_seg[10], LZB_BUILD ? 7'h7F : 7'h40);
        chk("lzb_d1", cap_seg[6], 7'h12);
        chk("lzb_d0", cap_seg[2], 7'h40);
        lzb = 1'b0;
        capture_frame();
        chk("nolzb_d3", cap_seg[14], 7'h40);
        chk("nolzb_d2", cap_seg[10], 7'h40);

        // Decimal point on digit 2 only
        do_load(16'h0050, 4'b0100);
        capture_frame();
        capture_frame();
        chk("dp_an2", cap_an[10], 4'hB);
        chk("dp_on2", cap_dp[10], 1'b0);
        chk("dp_off0", cap_dp[2], 1'b1);
        chk("dp_off3", cap_dp[14], 1'b1);

        // Reset mid-frame drops the pending value
        wait_state(4);
        do_load(16'hABCD, 4'b1111);
        chk("rst_pending_before", pending, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("rst_pending", pending, 1'b0);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'hF);
        chk("rst_seg_dp", seg_dp, 1'b1);
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_rel_an", an, 4'hF);
        @(posedge clk); #1;
        chk("rst_rel_an0", an, 4'hE);
        chk("rst_rel_seg0", seg, 7'h40);
        chk("rst_rel_dp0", seg_dp, 1'b1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
